// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between fetch and data requesters
module mem_port_arbiter #(
  parameter int          STARVE_LIMIT = 4,
  parameter int          TIMEOUT      = 16,
  parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_rdata,
  output logic        o_if_done,
  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  output logic [31:0] o_dm_rdata,
  output logic        o_dm_done,
  output logic        o_mem_valid,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata,
  output logic        o_stall_if,
  output logic        o_stall_mem,
  output logic        o_abort
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;
  state_t      r_state;
  logic        r_mem_valid, r_mem_we, r_if_done, r_dm_done, r_abort;
  logic [31:0] r_mem_addr, r_mem_wdata, r_if_rdata, r_dm_rdata;
  logic [SW-1:0] r_starve;
  logic [TW-1:0] r_tmo;
  logic        w_grant_if, w_finish;
  // Data wins a tie unless fetch has already been passed over STARVE_LIMIT times.
  assign w_grant_if = i_if_req && (!i_dm_req || r_starve == SW'(STARVE_LIMIT));
  assign w_finish   = i_mem_ready || r_tmo == TW'(TIMEOUT - 1);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_done   <= 1'b0;
      r_dm_done   <= 1'b0;
      r_abort     <= 1'b0;
      r_starve    <= '0;
      r_tmo       <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_if_req || i_dm_req) begin
          r_mem_valid <= 1'b1;
          r_mem_we    <= !w_grant_if && i_dm_we;
          r_mem_addr  <= w_grant_if ? i_if_addr : i_dm_addr;
          r_mem_wdata <= i_dm_wdata;
          r_starve    <= (w_grant_if || !i_if_req) ? '0 :
                         (r_starve == SW'(STARVE_LIMIT)) ? r_starve : r_starve + 1'b1;
          r_state     <= w_grant_if ? FETCH : DATA;
        end
        FETCH, DATA: begin
          r_tmo <= r_tmo + 1'b1;
          if (w_finish) begin
            r_mem_valid <= 1'b0;
            r_abort     <= !i_mem_ready;
            r_state     <= DONE;
            if (r_state == FETCH) begin
              r_if_done  <= 1'b1;
              r_if_rdata <= i_mem_ready ? i_mem_rdata : ERR_DATA;
            end else begin
              r_dm_done  <= 1'b1;
              if (!r_mem_we) r_dm_rdata <= i_mem_ready ? i_mem_rdata : ERR_DATA;
            end
          end
        end
        default: begin
          r_if_done <= 1'b0;
          r_dm_done <= 1'b0;
          r_abort   <= 1'b0;
          r_tmo     <= '0;
          r_state   <= IDLE;
        end
      endcase
    end
  end
  assign o_mem_valid = r_mem_valid;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_if_done   = r_if_done;
  assign o_dm_done   = r_dm_done;
  assign o_abort     = r_abort;
  assign o_stall_if  = i_if_req && !r_if_done;
  assign o_stall_mem = i_dm_req && !r_dm_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model
module tb_mem_port_arbiter;
  localparam int          SL  = 4;
  localparam int          TO  = 16;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
  logic        clk = 0, rst_n = 0;
  logic        if_req = 0, dm_req = 0, dm_we = 0, mem_ready = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic        o_if_done, o_dm_done, o_mem_valid, o_mem_we, o_stall_if, o_stall_mem, o_abort;
  logic [31:0] o_if_rdata, o_dm_rdata, o_mem_addr, o_mem_wdata;
  always #5 clk = ~clk;
  mem_port_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(o_if_rdata), .o_if_done(o_if_done),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .o_dm_rdata(o_dm_rdata), .o_dm_done(o_dm_done),
    .o_mem_valid(o_mem_valid), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .o_stall_if(o_stall_if), .o_stall_mem(o_stall_mem), .o_abort(o_abort));
  int n_chk = 0, n_err = 0;
  // Model: a transaction is either in flight (m_busy, with its age in busy cycles) or in turnaround.
  bit          m_busy, m_turn, m_fetch, m_hang, if_pend, dm_pend;
  int          m_age, m_starve;
  bit          e_valid, e_we, e_if_done, e_dm_done, e_abort;
  logic [31:0] e_addr, e_wdata, e_if_rdata, e_dm_rdata;
  logic [31:0] mem [logic [31:0]];
  string       grants;
  function automatic logic [31:0] rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : {a[15:0], 16'hC0DE};
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    m_busy = 0; m_turn = 0; m_fetch = 0; m_age = 0; m_starve = 0;
    e_valid = 0; e_we = 0; e_if_done = 0; e_dm_done = 0; e_abort = 0;
    e_addr = 0; e_wdata = 0; e_if_rdata = 0; e_dm_rdata = 0;
  endtask
  task automatic model_edge();
    if (m_turn) begin
      e_if_done = 0; e_dm_done = 0; e_abort = 0; m_turn = 0;
    end else if (m_busy) begin
      m_age++;
      if (mem_ready || m_age == TO) begin
        m_busy = 0; m_turn = 1; e_valid = 0; e_abort = !mem_ready;
        if (m_fetch) begin
          e_if_done = 1; e_if_rdata = mem_ready ? mem_rdata : ERR;
        end else begin
          e_dm_done = 1;
          if (!e_we) e_dm_rdata = mem_ready ? mem_rdata : ERR;
          else if (mem_ready) mem[e_addr] = e_wdata;
        end
      end
    end else if (if_req || dm_req) begin
      m_fetch  = if_req && (!dm_req || m_starve == SL);
      m_starve = (m_fetch || !if_req) ? 0 : (m_starve < SL ? m_starve + 1 : SL);
      m_busy = 1; m_age = 0; e_valid = 1;
      e_we = !m_fetch && dm_we; e_addr = m_fetch ? if_addr : dm_addr; e_wdata = dm_wdata;
      if (m_fetch) grants = {grants, "F"}; else grants = {grants, "D"};
    end
  endtask
  task automatic compare();
    chk("mem_valid", o_mem_valid, e_valid);
    if (e_valid) begin
      chk("mem_we", o_mem_we, e_we);
      chk("mem_addr", o_mem_addr, e_addr);
      if (e_we) chk("mem_wdata", o_mem_wdata, e_wdata);
    end
    chk("if_done", o_if_done, e_if_done);
    chk("dm_done", o_dm_done, e_dm_done);
    chk("abort", o_abort, e_abort);
    chk("if_rdata", o_if_rdata, e_if_rdata);
    chk("dm_rdata", o_dm_rdata, e_dm_rdata);
    chk("stall_if", o_stall_if, if_req && !e_if_done);
    chk("stall_mem", o_stall_mem, dm_req && !e_dm_done);
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1 compare();
  endtask
  task automatic settle();
    int k = 0;
    if_req = 0; dm_req = 0;
    while ((m_busy || m_turn) && k < 50) begin
      mem_ready = e_valid; mem_rdata = rd(e_addr);
      step(); k++;
    end
    mem_ready = 0;
    chk("settle bound", {31'b0, m_busy | m_turn}, 0);
  endtask
  task automatic drive_random();
    if (e_if_done) begin
      if_pend = $urandom_range(0, 1); if_req = if_pend;
      if (if_pend) if_addr = {$urandom_range(0, 255), 2'b00};
    end else if (!if_pend && $urandom_range(0, 2) == 0) begin
      if_pend = 1; if_req = 1; if_addr = {$urandom_range(0, 255), 2'b00};
    end else if (if_req && m_busy && m_fetch && $urandom_range(0, 15) == 0) if_req = 0;
    if (e_dm_done || (!dm_pend && $urandom_range(0, 2) == 0)) begin
      dm_pend = e_dm_done ? 1'($urandom_range(0, 1)) : 1'b1; dm_req = dm_pend;
      dm_we = 1'($urandom_range(0, 1)); dm_addr = 32'h100 + {$urandom_range(0, 7), 2'b00};
      dm_wdata = $urandom;
    end else if (dm_req && m_busy && !m_fetch && $urandom_range(0, 15) == 0) dm_req = 0;
    if (m_busy && m_age == 0) m_hang = ($urandom_range(0, 7) == 0);
    mem_ready = e_valid ? (!m_hang && $urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
    mem_rdata = e_valid ? rd(e_addr) : $urandom;
  endtask
  initial begin
    int cnt;
    model_reset(); grants = "";
    #2 compare();
    chk("reset mem_addr", o_mem_addr, 0);
    chk("reset mem_wdata", o_mem_wdata, 0);
    @(negedge clk); rst_n = 1;
    step();
    // Single fetch
    if_req = 1; if_addr = 32'h40;
    step();
    chk("t1 mem_valid", o_mem_valid, 1);
    chk("t1 mem_addr", o_mem_addr, 32'h40);
    chk("t1 mem_we", o_mem_we, 0);
    mem_ready = 1; mem_rdata = 32'h00500093;
    step();
    chk("t1 if_done", o_if_done, 1);
    chk("t1 if_rdata", o_if_rdata, 32'h00500093);
    if_req = 0; mem_ready = 0;
    step();
    chk("t1 stall_if", o_stall_if, 0);
    // Store then load
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hCAFEF00D;
    step();
    chk("t2 mem_we", o_mem_we, 1);
    chk("t2 mem_wdata", o_mem_wdata, 32'hCAFEF00D);
    mem_ready = 1; mem_rdata = 32'h12345678;
    step();
    chk("t2 st done", o_dm_done, 1);
    dm_req = 0; mem_ready = 0;
    step();
    dm_req = 1; dm_we = 0; dm_wdata = 0;
    step();
    mem_ready = 1; mem_rdata = rd(32'h100);
    step();
    chk("t2 ld done", o_dm_done, 1);
    chk("t2 ld data", o_dm_rdata, 32'hCAFEF00D);
    settle();
    // Contention: both held continuously
    grants = ""; cnt = 0;
    if_req = 1; dm_req = 1; dm_we = 0; if_addr = 32'h200; dm_addr = 32'h104;
    while (grants.len() < 10 && cnt < 200) begin
      mem_ready = e_valid; mem_rdata = rd(e_addr);
      step(); cnt++;
      if (m_busy && !m_fetch) chk("t3 stall_if", o_stall_if, 1);
    end
    n_chk++;
    if (grants != "DDDDFDDDDF") begin
      n_err++; $display("FAIL t3 grant order: got %s, expected DDDDFDDDDF", grants);
    end
    settle();
    // Timeout on a load
    dm_req = 1; dm_we = 0; dm_addr = 32'h300; mem_ready = 0;
    step();
    cnt = 0;
    do begin step(); cnt++; end while (!o_abort && cnt < 40);
    chk("t4 abort delay", cnt, 16);
    chk("t4 dm_done", o_dm_done, 1);
    chk("t4 dm_rdata", o_dm_rdata, ERR);
    dm_req = 0;
    step();
    chk("t4 abort clr", o_abort, 0);
    step();
    // Async reset mid-transaction, with fetch already starved to the limit
    grants = ""; cnt = 0;
    if_req = 1; dm_req = 1; dm_we = 1; dm_addr = 32'h108; dm_wdata = 32'h0BADF00D;
    while (grants.len() < 4 && cnt < 100) begin
      mem_ready = e_valid && grants.len() < 4; mem_rdata = rd(e_addr);
      step(); cnt++;
      if (grants.len() == 4) mem_ready = 0;
    end
    chk("t5 in DATA", o_mem_valid, 1);
    #3 rst_n = 0;
    #1 chk("t5 async drop", o_mem_valid, 0);
    model_reset(); compare();
    @(negedge clk); rst_n = 1;
    grants = "";
    step();
    n_chk++;
    if (grants != "D") begin
      n_err++; $display("FAIL t5 regrant: got %s, expected D", grants);
    end
    chk("t5 mem_we", o_mem_we, 1);
    settle();
    // Dropped request
    if_req = 1; if_addr = 32'h80;
    step();
    if_req = 0;
    step(); step();
    mem_ready = 1; mem_rdata = 32'h00000013;
    step();
    chk("t6 if_done", o_if_done, 1);
    mem_ready = 0;
    step();
    chk("t6 single pulse", o_if_done, 0);
    dm_req = 1; dm_we = 0; dm_addr = 32'h10C;
    step();
    chk("t6 next grant", o_mem_valid, 1);
    settle();
    // Random traffic
    if_pend = 0; dm_pend = 0; m_hang = 0;
    repeat (3000) begin
      drive_random();
      step();
    end
    settle();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
